key_debounce: RTL
=================

# key_debounce

Front-end conditioning stage for the plot-selection buttons. It synchronises the three raw push-button inputs to `sysclk` and debounces each one. It then emits clean single-cycle pulses for Next, Previous and Auto-toggle, with optional hold-to-repeat on Next/Previous. Its pulse outputs drive the plot-address stage directly, so one physical press advances the plot exactly once.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before the clean level changes (min 2).
- `REPEAT_DELAY`, default 50_000_000: cycles from the first press pulse to the first repeat pulse (min 2).
- `REPEAT_PERIOD`, default 20_000_000: cycles between later repeat pulses (min 2).
- `REPEAT_EN`, default 3'b011: per-channel repeat enable; bit 0 Next, bit 1 Pre, bit 2 Auto.
- `sysclk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  3  raw asynchronous buttons, active-high; [0] Next, [1] Pre, [2] Auto.
- `pulse_next`  out  1  one-cycle Next pulse.
- `pulse_pre`  out  1  one-cycle Previous pulse.
- `pulse_auto`  out  1  one-cycle Auto-toggle pulse.
- `btn_level`  out  3  debounced button levels, for status LEDs.

## Operation
- Per channel, a 2-FF synchroniser produces `s2`, followed by a debounce filter and a pulse FSM.
- Filter, counter rule:
  - While `s2` != clean level, the counter increments.
  - Whenever `s2` == level, the counter clears to 0.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and `s2` still differs, the level flips on the next edge and the counter clears.
- Pulse FSM states are IDLE, HELD and REPEAT.
  - IDLE: on level 0->1, assert the raw pulse for one cycle and go to HELD. The repeat counter is cleared.
  - HELD: the repeat counter counts. At `REPEAT_DELAY-1`, if `REPEAT_EN[ch]`, emit a pulse, clear the counter and go to REPEAT. If repeat is disabled, stay in HELD until release.
  - REPEAT: at `REPEAT_PERIOD-1`, emit a pulse and clear the counter.
  - From any state, level 1->0 returns to IDLE and clears the counter. No pulse is emitted on release.
- Conflict rule: if the raw Next and Pre pulses occur in the same cycle, both are suppressed for that cycle. Auto is never suppressed.
- Pulse outputs are registered. A pulse is never longer than 1 cycle, and a channel's pulses are never closer than 2 cycles apart.
- Counter widths are `$clog2(max value)+1`. Counters saturate and never wrap, so a held button never produces spurious pulses from overflow.

## Timing
- Reset values: all outputs, synchroniser flops, levels and counters are 0, and every FSM is in IDLE.
- A button held through reset release yields a press pulse once debounce completes.
- Press latency: with `btn_raw` stable from sampling edge 0, `btn_level` rises and the pulse asserts together at edge `DEBOUNCE_CYCLES+2`. The pulse is high for exactly one cycle.
- Release latency: `btn_level` falls at edge `DEBOUNCE_CYCLES+2` after the raw fall.
- Bounce: any glitch back to the current level restarts the count from 0.
- First repeat: `REPEAT_DELAY` cycles after the press pulse. Later repeats follow every `REPEAT_PERIOD` cycles.
- Reset mid-operation clears everything immediately (asynchronous). Any pulse in flight is dropped, and a pulse is never emitted on the edge where reset deasserts.

## Structure
- Shared package `key_pkg`:
  - channel index constants `KEY_NEXT=0`, `KEY_PRE=1`, `KEY_AUTO=2`, and `KEY_N=3`;
  - the pulse FSM state enum `key_state_t`, encoded IDLE/HELD/REPEAT.
- Sub-module `key_debounce_chan`: synchroniser, filter, FSM and repeat counter for one channel, with parameters passed down. It is instantiated `KEY_N` times.
- The top level adds the Next/Pre conflict suppression and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=8`, `REPEAT_EN=3'b011`.
- Clean press: Next held for 10 cycles -> `pulse_next` is high only at edge 6. `btn_level[0]` rises at edge 6 and falls 6 cycles after release.
- Bounce: Pre toggled 1,0,1,0,1 (one cycle each), then held -> exactly one `pulse_pre`, 6 edges after the final rise.
- Repeat: Next held for 60 cycles -> pulses at edges 6, 26, 34, 42, 50 and 58, with none after release.
- Auto hold: Auto held for 60 cycles -> a single `pulse_auto` at edge 6, with no repeats.
- Conflict: Next and Pre pressed on the same cycle -> no `pulse_next` and no `pulse_pre` at edge 6. Both levels still go to 1.
- Reset: Next held and `rst` pulsed at cycle 5 -> outputs 0 immediately. After reset release, one `pulse_next` arrives `DEBOUNCE_CYCLES+2` edges later.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the plot-selection button front end.
//   KEY_NEXT/KEY_PRE/KEY_AUTO : channel indices into btn_raw / btn_level
//   KEY_N                     : number of button channels
//   key_state_t               : per-channel pulse FSM state
package key_pkg;

    localparam int KEY_NEXT = 0;
    localparam int KEY_PRE  = 1;
    localparam int KEY_AUTO = 2;
    localparam int KEY_N    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: groups the button inputs and conditioned outputs.
//   btn_raw    : raw asynchronous buttons, active-high ([0] Next, [1] Pre, [2] Auto)
//   pulse_next : one-cycle Next pulse
//   pulse_pre  : one-cycle Previous pulse
//   pulse_auto : one-cycle Auto-toggle pulse
//   btn_level  : debounced button levels
// master drives the buttons and observes the outputs; slave is the debouncer.
interface key_debounce_if;
    import key_pkg::*;

    logic [KEY_N-1:0] btn_raw;
    logic             pulse_next;
    logic             pulse_pre;
    logic             pulse_auto;
    logic [KEY_N-1:0] btn_level;

    modport master (
        output btn_raw,
        input  pulse_next,
        input  pulse_pre,
        input  pulse_auto,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        output pulse_next,
        output pulse_pre,
        output pulse_auto,
        output btn_level
    );

endinterface

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one button channel.
//   sysclk : system clock (rising edge)
//   rst    : asynchronous active-high reset
//   btn    : raw asynchronous button
//   level  : debounced level (unregistered copy of the filter state)
//   pulse  : combinational press/repeat pulse, registered by the parent
// Contains the 2-FF synchroniser, the debounce filter, the pulse FSM and
// the repeat counter.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 20_000_000,
    parameter bit          REPEAT_ENABLE   = 1'b1
) (
    input  logic sysclk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax) + 1;

    localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] PerLast   = RepW'(REPEAT_PERIOD - 1);

    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    key_state_t      state_q, state_d;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            state_q   <= IDLE;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
        end
    end

    // Filter: any sample matching the current level restarts the count.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (s2_q != level_q) begin
            if (db_cnt_q == DbLast) begin
                level_d  = s2_q;
                db_cnt_d = '0;
            end else if (db_cnt_q != '1) begin
                db_cnt_d = db_cnt_q + 1'b1;
            end else begin
                db_cnt_d = db_cnt_q;
            end
        end
    end

    // Saturating increment so a long hold with repeat disabled never wraps.
    assign rep_inc = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        pulse     = 1'b0;
        unique case (state_q)
            IDLE: begin
                rep_cnt_d = '0;
                if (level_q) begin
                    pulse   = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (!level_q) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (REPEAT_ENABLE && rep_cnt_q == DelayLast) begin
                    pulse     = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = REPEAT;
                end else begin
                    rep_cnt_d = rep_inc;
                end
            end
            REPEAT: begin
                // Release wins over a coincident repeat tick.
                if (!level_q) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == PerLast) begin
                    pulse     = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end

    assign level = level_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: conditioning front end for the plot-selection buttons.
//   sysclk : system clock (rising edge)
//   rst    : asynchronous active-high reset
//   bus    : key_debounce_if.slave (btn_raw in; pulse_next/pre/auto, btn_level out)
// Per-channel debounce and pulse generation, Next/Pre conflict suppression,
// and registered outputs. Levels are registered alongside the pulses so a
// press shows up on btn_level and the pulse in the same cycle.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned      REPEAT_DELAY    = 50_000_000,
    parameter int unsigned      REPEAT_PERIOD   = 20_000_000,
    parameter logic [KEY_N-1:0] REPEAT_EN       = 3'b011
) (
    input  logic          sysclk,
    input  logic          rst,
    key_debounce_if.slave bus
);

    logic [KEY_N-1:0] chan_level;
    logic [KEY_N-1:0] chan_pulse;
    logic [KEY_N-1:0] pulse_d, pulse_q;
    logic [KEY_N-1:0] level_q;

    for (genvar ch = 0; ch < KEY_N; ch++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_ENABLE   (REPEAT_EN[ch])
        ) u_chan (
            .sysclk (sysclk),
            .rst    (rst),
            .btn    (bus.btn_raw[ch]),
            .level  (chan_level[ch]),
            .pulse  (chan_pulse[ch])
        );
    end

    // Simultaneous Next and Pre is ambiguous, so neither is forwarded.
    always_comb begin
        pulse_d = chan_pulse;
        if (chan_pulse[KEY_NEXT] && chan_pulse[KEY_PRE]) begin
            pulse_d[KEY_NEXT] = 1'b0;
            pulse_d[KEY_PRE]  = 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
            level_q <= '0;
        end else begin
            pulse_q <= pulse_d;
            level_q <= chan_level;
        end
    end

    assign bus.pulse_next = pulse_q[KEY_NEXT];
    assign bus.pulse_pre  = pulse_q[KEY_PRE];
    assign bus.pulse_auto = pulse_q[KEY_AUTO];
    assign bus.btn_level  = level_q;

endmodule
